// File: rtl/gpio_debounce_pkg.sv
// Shared constants for the GPIO debouncer: CSR word offsets and per-pin counter width.
// Imported by the RTL and by the testbench so both agree on the register map.
package gpio_debounce_pkg;
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] count_t;

    localparam logic [2:0] OFF_SYNC  = 3'd0;
    localparam logic [2:0] OFF_CLEAN = 3'd1;
    localparam logic [2:0] OFF_DIV   = 3'd2;
    localparam logic [2:0] OFF_THR   = 3'd3;
    localparam logic [2:0] OFF_EVENT = 3'd4;
    localparam logic [2:0] OFF_IRQEN = 3'd5;
endpackage

// File: rtl/gpio_debounce_cell.sv
// One debounced pin: two-flop synchronizer, stable-tick counter and clean level.
// evt_set pulses in the cycle the clean level is about to change.
module gpio_debounce_cell
    import gpio_debounce_pkg::*;
(
    input  logic   clk,
    input  logic   srst,
    input  logic   raw,
    input  logic   tick,
    input  count_t thr,
    input  logic   clr,
    output logic   sync,
    output logic   clean,
    output logic   evt_set
);
    logic           meta_reg;
    logic           sync_reg;
    logic           clean_reg;
    count_t         count_reg;
    logic           clean_next;
    count_t         count_next;
    logic [CNT_W:0] count_inc;

    assign count_inc = {1'b0, count_reg} + 5'd1;
    assign sync      = sync_reg;
    assign clean     = clean_reg;

    always_comb begin
        clean_next = clean_reg;
        count_next = count_reg;
        evt_set    = 1'b0;
        if (thr == '0) begin
            // Bypass: follow the synchronized level every cycle.
            count_next = '0;
            clean_next = sync_reg;
            evt_set    = sync_reg != clean_reg;
        end else if (clr) begin
            count_next = '0;
        end else if (tick) begin
            if (sync_reg == clean_reg) begin
                count_next = '0;
            end else if (count_inc == {1'b0, thr}) begin
                clean_next = sync_reg;
                count_next = '0;
                evt_set    = 1'b1;
            end else if (count_reg != '1) begin
                count_next = count_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            clean_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            meta_reg  <= raw;
            sync_reg  <= meta_reg;
            clean_reg <= clean_next;
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/gpio_debounce.sv
// GPIO debouncer bank: shared prescaler, per-pin debounce cells, event/irq logic
// and a small CSR slave selected by csr_a[13:10].
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter logic [3:0]  csr_addr    = 4'h0,
    parameter int          ninputs     = 16,
    parameter logic [15:0] default_div = 16'd999,
    parameter logic [3:0]  default_thr = 4'd8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [ninputs-1:0] pins_raw,
    output logic [ninputs-1:0] pins_clean,
    output logic               irq,
    input  logic [13:0]        csr_a,
    input  logic               csr_we,
    input  logic [31:0]        csr_di,
    output logic [31:0]        csr_do
);
    logic [15:0]        div_reg;
    logic [15:0]        presc_reg;
    count_t             thr_reg;
    logic [ninputs-1:0] sync_bus;
    logic [ninputs-1:0] set_bus;
    logic [ninputs-1:0] event_reg;
    logic [ninputs-1:0] irqen_reg;
    logic [ninputs-1:0] w1c;
    logic               tick;
    logic               sel;
    logic               wr;
    logic               thr_wr;
    logic [31:0]        rd_next;
    logic               unused_bits;

    // Address bits between the bank select and the offset are not decoded.
    assign unused_bits = ^{csr_a[9:3], csr_di};

    assign tick   = presc_reg == 16'd0;
    assign sel    = csr_a[13:10] == csr_addr;
    assign wr     = csr_we && sel;
    assign thr_wr = wr && (csr_a[2:0] == OFF_THR);
    assign w1c    = (wr && (csr_a[2:0] == OFF_EVENT)) ? csr_di[ninputs-1:0] : '0;

    generate
        for (genvar gi = 0; gi < ninputs; gi++) begin : g_pin
            gpio_debounce_cell u_cell (
                .clk     (sys_clk),
                .srst    (sys_rst),
                .raw     (pins_raw[gi]),
                .tick    (tick),
                .thr     (thr_reg),
                .clr     (thr_wr),
                .sync    (sync_bus[gi]),
                .clean   (pins_clean[gi]),
                .evt_set (set_bus[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_next = '0;
        if (sel) begin
            case (csr_a[2:0])
                OFF_SYNC:  rd_next[ninputs-1:0] = sync_bus;
                OFF_CLEAN: rd_next[ninputs-1:0] = pins_clean;
                OFF_DIV:   rd_next[15:0]        = div_reg;
                OFF_THR:   rd_next[CNT_W-1:0]   = thr_reg;
                OFF_EVENT: rd_next[ninputs-1:0] = event_reg;
                OFF_IRQEN: rd_next[ninputs-1:0] = irqen_reg;
                default:   rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_reg   <= default_div;
            presc_reg <= default_div;
            thr_reg   <= default_thr;
            event_reg <= '0;
            irqen_reg <= '0;
            irq       <= 1'b0;
            csr_do    <= '0;
        end else begin
            // A div write restarts the prescaler from the new value at once.
            if (wr && (csr_a[2:0] == OFF_DIV)) begin
                div_reg   <= csr_di[15:0];
                presc_reg <= csr_di[15:0];
            end else if (tick) begin
                presc_reg <= div_reg;
            end else begin
                presc_reg <= presc_reg - 16'd1;
            end
            if (thr_wr) begin
                thr_reg <= csr_di[CNT_W-1:0];
            end
            if (wr && (csr_a[2:0] == OFF_IRQEN)) begin
                irqen_reg <= csr_di[ninputs-1:0];
            end
            // New events win over a simultaneous clear.
            event_reg <= (event_reg & ~w1c) | set_bus;
            irq       <= |(event_reg & irqen_reg);
            csr_do    <= rd_next;
        end
    end
endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce with a cycle-level reference model checked every cycle.
module tb_gpio_debounce;
    import gpio_debounce_pkg::*;

    localparam int NIN = 16;

    logic            clk = 1'b0;
    logic            sys_rst;
    logic [NIN-1:0]  pins_raw;
    logic [NIN-1:0]  pins_clean;
    logic            irq;
    logic [13:0]     csr_a;
    logic            csr_we;
    logic [31:0]     csr_di;
    logic [31:0]     csr_do;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_debounce #(
        .csr_addr    (4'h0),
        .ninputs     (NIN),
        .default_div (16'd999),
        .default_thr (4'd8)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .pins_raw   (pins_raw),
        .pins_clean (pins_clean),
        .irq        (irq),
        .csr_a      (csr_a),
        .csr_we     (csr_we),
        .csr_di     (csr_di),
        .csr_do     (csr_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as seen after each rising edge.
    logic [NIN-1:0] m_meta = '0, m_sync = '0, m_clean = '0, m_ev = '0, m_ien = '0;
    logic           m_irq = 1'b0;
    logic [31:0]    m_do = '0;
    int             m_div = 999, m_thr = 8;
    int             run [NIN];
    longint         cyc = 0, next_tick = 0;
    bit             started = 1'b0;

    always @(posedge clk) begin : model
        logic           wr, tick;
        logic [2:0]     off;
        logic [NIN-1:0] setv, w1c;
        wr  = csr_we && (csr_a[13:10] == 4'h0);
        off = csr_a[2:0];
        if (sys_rst) begin
            m_meta = '0; m_sync = '0; m_clean = '0; m_ev = '0; m_ien = '0;
            m_irq = 1'b0; m_do = '0; m_div = 999; m_thr = 8;
            for (int p = 0; p < NIN; p++) run[p] = 0;
            next_tick = cyc + 1 + 999;
            started = 1'b1;
        end else begin
            tick = (cyc == next_tick);
            m_do = '0;
            if (csr_a[13:10] == 4'h0) begin
                case (off)
                    OFF_SYNC:  m_do = 32'(m_sync);
                    OFF_CLEAN: m_do = 32'(m_clean);
                    OFF_DIV:   m_do = 32'(m_div);
                    OFF_THR:   m_do = 32'(m_thr);
                    OFF_EVENT: m_do = 32'(m_ev);
                    OFF_IRQEN: m_do = 32'(m_ien);
                    default:   m_do = '0;
                endcase
            end
            m_irq = |(m_ev & m_ien);
            setv = '0;
            // run[p] = consecutive ticks on which the synced level disagreed with clean.
            for (int p = 0; p < NIN; p++) begin
                if (m_thr == 0) begin
                    run[p] = 0;
                    if (m_sync[p] != m_clean[p]) begin
                        setv[p] = 1'b1;
                        m_clean[p] = m_sync[p];
                    end
                end else if (wr && off == OFF_THR) begin
                    run[p] = 0;
                end else if (tick) begin
                    if (m_sync[p] == m_clean[p]) run[p] = 0;
                    else if (run[p] + 1 == m_thr) begin
                        m_clean[p] = m_sync[p];
                        run[p] = 0;
                        setv[p] = 1'b1;
                    end else if (run[p] < 15) run[p] = run[p] + 1;
                end
            end
            w1c = (wr && off == OFF_EVENT) ? csr_di[NIN-1:0] : '0;
            m_ev = (m_ev & ~w1c) | setv;
            m_sync = m_meta;
            m_meta = pins_raw;
            if (wr && off == OFF_DIV) next_tick = cyc + 1 + longint'(csr_di[15:0]);
            else if (tick) next_tick = cyc + 1 + m_div;
            if (wr && off == OFF_DIV)   m_div = int'(csr_di[15:0]);
            if (wr && off == OFF_THR)   m_thr = int'(csr_di[3:0]);
            if (wr && off == OFF_IRQEN) m_ien = csr_di[NIN-1:0];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_clean", 32'(pins_clean), 32'(m_clean));
            check("model_irq", 32'(irq), 32'(m_irq));
            check("model_csr_do", csr_do, m_do);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] off, input logic [31:0] d);
        csr_a  = {4'h0, 7'd0, off};
        csr_di = d;
        csr_we = 1'b1;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        $display("csr write off=%0d data=%h", off, d);
    endtask

    task automatic csr_read(input logic [3:0] bank, input logic [2:0] off, output logic [31:0] d);
        csr_a  = {bank, 7'd0, off};
        csr_we = 1'b0;
        @(posedge clk);
        #1;
        d = csr_do;
        $display("csr read bank=%0d off=%0d data=%h", bank, off, d);
    endtask

    initial begin
        logic [31:0] d;
        sys_rst = 1'b1; pins_raw = '0; csr_a = '0; csr_we = 1'b0; csr_di = '0;
        step(3);
        sys_rst = 1'b0;
        check("rst_clean", 32'(pins_clean), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_csr_do", csr_do, 32'h0);
        csr_read(4'h0, OFF_DIV, d);   check("rst_div", d, 32'd999);
        csr_read(4'h0, OFF_THR, d);   check("rst_thr", d, 32'd8);
        csr_read(4'h1, OFF_DIV, d);   check("unselected_read", d, 32'h0);

        // Held edge with div=0, thr=3: clean follows 2+3 cycles later.
        csr_write(OFF_DIV, 32'd0);
        csr_write(OFF_THR, 32'd3);
        step(4);
        pins_raw[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            if (i == 4) check("held_clean_at4", 32'(pins_clean[0]), 32'h0);
            if (i == 5) check("held_clean_at5", 32'(pins_clean[0]), 32'h1);
        end
        csr_read(4'h0, OFF_EVENT, d); check("held_event", d, 32'h1);
        csr_write(OFF_EVENT, 32'h1);
        csr_read(4'h0, OFF_EVENT, d); check("w1c_event", d, 32'h0);

        // Two-cycle glitch on pin2 is rejected.
        pins_raw[2] = 1'b1;
        step(2);
        pins_raw[2] = 1'b0;
        step(10);
        check("glitch_clean", 32'(pins_clean[2]), 32'h0);
        csr_read(4'h0, OFF_EVENT, d); check("glitch_event", d, 32'h0);

        // thr=0 bypass: pin5 follows with 3 cycles of delay.
        csr_write(OFF_THR, 32'd0);
        step(2);
        pins_raw[5] = 1'b1;
        step(2);
        check("bypass_clean_at2", 32'(pins_clean[5]), 32'h0);
        step(1);
        check("bypass_clean_at3", 32'(pins_clean[5]), 32'h1);
        repeat (6) begin
            step(4);
            pins_raw[5] = ~pins_raw[5];
        end
        step(4);
        csr_read(4'h0, OFF_EVENT, d); check("bypass_event", d, 32'h20);
        csr_write(OFF_EVENT, 32'hffff);

        // Clear coinciding with a new event on pin0: the event survives.
        csr_write(OFF_IRQEN, 32'h1);
        pins_raw[0] = 1'b0;
        step(6);
        check("irq_on", 32'(irq), 32'h1);
        pins_raw[0] = 1'b1;
        step(2);
        csr_write(OFF_EVENT, 32'h1);
        csr_read(4'h0, OFF_EVENT, d); check("set_wins_event", d, 32'h1);
        check("set_wins_irq", 32'(irq), 32'h1);
        csr_write(OFF_EVENT, 32'h1);
        step(2);
        check("irq_off", 32'(irq), 32'h0);

        // Prescaled debounce, then restart the prescaler with div=0 mid-count.
        csr_write(OFF_THR, 32'd2);
        csr_write(OFF_DIV, 32'd9);
        pins_raw[1] = 1'b1;
        step(3);
        check("presc_clean_early", 32'(pins_clean[1]), 32'h0);
        step(27);
        check("presc_clean_late", 32'(pins_clean[1]), 32'h1);
        pins_raw[1] = 1'b0;
        step(5);
        csr_write(OFF_DIV, 32'd0);
        step(3);
        check("presc_restart", 32'(pins_clean[1]), 32'h0);

        // Reset with a partial count discards it and restores defaults.
        csr_write(OFF_THR, 32'd3);
        csr_write(OFF_IRQEN, 32'h8);
        pins_raw[3] = 1'b1;
        step(4);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        check("mid_rst_clean", 32'(pins_clean), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_csr_do", csr_do, 32'h0);
        csr_read(4'h0, OFF_DIV, d);   check("mid_rst_div", d, 32'd999);
        csr_read(4'h0, OFF_THR, d);   check("mid_rst_thr", d, 32'd8);
        csr_read(4'h0, OFF_EVENT, d); check("mid_rst_event", d, 32'h0);
        csr_read(4'h0, OFF_IRQEN, d); check("mid_rst_irqen", d, 32'h0);
        csr_read(4'h0, 3'd6, d);      check("unmapped_read", d, 32'h0);
        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
